// File: rtl/mure_retire_packer_if.sv
// Interface: mure_retire_packer_if
// Commit-group input bus and block-beat output bus of mure_retire_packer.
// The master drives commit groups and accepts beats; the slave is the packer.
interface mure_retire_packer_if #(
  parameter int NRET        = 2,
  parameter int NBLK        = 2,
  parameter int XLEN        = 32,
  parameter int ITYPE_LEN   = 4,
  parameter int IRETIRE_LEN = 8,
  parameter int PRIV_LEN    = 2,
  parameter int CAUSE_LEN   = 8
) ();

  logic [NRET-1:0]                 valid_i;
  logic [NRET-1:0][XLEN-1:0]       pc_i;
  logic [NRET-1:0][ITYPE_LEN-1:0]  itype_i;
  logic [NRET-1:0]                 compr_i;
  logic [PRIV_LEN-1:0]             priv_i;
  logic [CAUSE_LEN-1:0]            cause_i;
  logic [XLEN-1:0]                 tval_i;
  logic                            ready_o;

  logic [NBLK-1:0]                 out_valid_o;
  logic                            out_ready_i;
  logic [NBLK-1:0][IRETIRE_LEN-1:0] iretire_o;
  logic [NBLK-1:0]                 ilastsize_o;
  logic [NBLK-1:0][ITYPE_LEN-1:0]  itype_o;
  logic [NBLK-1:0][CAUSE_LEN-1:0]  cause_o;
  logic [NBLK-1:0][XLEN-1:0]       tval_o;
  logic [NBLK-1:0][PRIV_LEN-1:0]   priv_o;
  logic [NBLK-1:0][XLEN-1:0]       iaddr_o;

  modport master (
    output valid_i, pc_i, itype_i, compr_i, priv_i, cause_i, tval_i, out_ready_i,
    input  ready_o, out_valid_o, iretire_o, ilastsize_o, itype_o, cause_o, tval_o,
           priv_o, iaddr_o
  );

  modport slave (
    input  valid_i, pc_i, itype_i, compr_i, priv_i, cause_i, tval_i, out_ready_i,
    output ready_o, out_valid_o, iretire_o, ilastsize_o, itype_o, cause_o, tval_o,
           priv_o, iaddr_o
  );

endinterface

// File: rtl/mure_retire_packer.sv
// Module: mure_retire_packer
// Buffers NRET-wide commit groups in a FIFO, walks one lane of the head group
// per cycle and merges retirements into E-trace blocks, which are handed to the
// encoder up to NBLK blocks per output beat.
// Optional build macro MURE_PACKER_PRIV_CHANGE_EN: a valid lane whose privilege
// differs from the open block's privilege first closes that block.
module mure_retire_packer #(
  parameter int NRET        = 2,
  parameter int NBLK        = 2,
  parameter int DEPTH       = 16,
  parameter int XLEN        = 32,
  parameter int ITYPE_LEN   = 4,
  parameter int IRETIRE_LEN = 8,
  parameter int PRIV_LEN    = 2,
  parameter int CAUSE_LEN   = 8
) (
  input logic                 clk_i,
  input logic                 rst_ni,
  mure_retire_packer_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = (NRET > 1) ? $clog2(NRET) : 1;
  localparam int FW = $clog2(NBLK + 1);

  localparam logic [IRETIRE_LEN:0]   ACC_MAX   = {1'b0, {IRETIRE_LEN{1'b1}}};
  localparam logic [AW:0]            PTR_ONE   = (AW + 1)'(1);
  localparam logic [ITYPE_LEN-1:0]   ITYPE_STD = '0;
  localparam logic [ITYPE_LEN-1:0]   ITYPE_EXC = ITYPE_LEN'(1);
  localparam logic [ITYPE_LEN-1:0]   ITYPE_INT = ITYPE_LEN'(2);

  typedef struct packed {
    logic [NRET-1:0]                valid;
    logic [NRET-1:0][XLEN-1:0]      pc;
    logic [NRET-1:0][ITYPE_LEN-1:0] itype;
    logic [NRET-1:0]                compr;
    logic [PRIV_LEN-1:0]            priv;
    logic [CAUSE_LEN-1:0]           cause;
    logic [XLEN-1:0]                tval;
  } group_t;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DRAIN
  } state_t;

  // Group FIFO
  group_t      mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        empty;
  logic        full;
  logic        push;
  group_t      incoming;
  group_t      head;

  // Packing state
  state_t                 state;
  logic [LW-1:0]          lptr;
  logic [IRETIRE_LEN-1:0] acc;
  logic                   open;
  logic [XLEN-1:0]        iaddr_start;
  logic                   last_compr;
  logic [FW-1:0]          fill;
  logic [NBLK-1:0]        out_valid;
`ifdef MURE_PACKER_PRIV_CHANGE_EN
  logic [PRIV_LEN-1:0]    open_priv;
  logic [PRIV_LEN-1:0]    n_open_priv;
`endif

  // Output slots
  logic [NBLK-1:0][IRETIRE_LEN-1:0] blk_iretire;
  logic [NBLK-1:0]                  blk_ilastsize;
  logic [NBLK-1:0][ITYPE_LEN-1:0]   blk_itype;
  logic [NBLK-1:0][CAUSE_LEN-1:0]   blk_cause;
  logic [NBLK-1:0][XLEN-1:0]        blk_tval;
  logic [NBLK-1:0][PRIV_LEN-1:0]    blk_priv;
  logic [NBLK-1:0][XLEN-1:0]        blk_iaddr;

  // Current lane view
  logic                 lane_valid;
  logic [XLEN-1:0]      lane_pc;
  logic [ITYPE_LEN-1:0] lane_itype;
  logic                 lane_compr;

  // Per-cycle decision
  logic                   is_trap;
  logic                   is_special;
  logic                   priv_change;
  logic                   overflow;
  logic [IRETIRE_LEN:0]   inc;
  logic [IRETIRE_LEN:0]   sum;
  logic [PRIV_LEN-1:0]    close_priv;
  logic                   close;
  logic                   consume;
  logic                   trap;
  logic                   group_done;
  logic [IRETIRE_LEN-1:0] c_iretire;
  logic                   c_ilastsize;
  logic [ITYPE_LEN-1:0]   c_itype;
  logic [CAUSE_LEN-1:0]   c_cause;
  logic [XLEN-1:0]        c_tval;
  logic [XLEN-1:0]        c_iaddr;
  logic [IRETIRE_LEN-1:0] n_acc;
  logic                   n_open;
  logic [XLEN-1:0]        n_start;
  logic                   n_last;
  logic [FW-1:0]          fill_next;
  logic                   beat_full;
  logic [NBLK-1:0]        therm;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign push  = (|bus.valid_i) && !full;
  assign head  = mem[rd_ptr[AW-1:0]];

  assign incoming.valid = bus.valid_i;
  assign incoming.pc    = bus.pc_i;
  assign incoming.itype = bus.itype_i;
  assign incoming.compr = bus.compr_i;
  assign incoming.priv  = bus.priv_i;
  assign incoming.cause = bus.cause_i;
  assign incoming.tval  = bus.tval_i;

  assign bus.ready_o     = !full;
  assign bus.out_valid_o = out_valid;
  assign bus.iretire_o   = blk_iretire;
  assign bus.ilastsize_o = blk_ilastsize;
  assign bus.itype_o     = blk_itype;
  assign bus.cause_o     = blk_cause;
  assign bus.tval_o      = blk_tval;
  assign bus.priv_o      = blk_priv;
  assign bus.iaddr_o     = blk_iaddr;

  // Store an incoming group; storage needs no reset since the pointers guard it
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= incoming;
    end
  end

  // Advance the write pointer on every accepted group; a push while full is dropped
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
    end else if (push) begin
      wr_ptr <= wr_ptr + PTR_ONE;
    end
  end

  // Select the lane of the head group that the walker points at
  always_comb begin
    lane_valid = 1'b0;
    lane_pc    = '0;
    lane_itype = '0;
    lane_compr = 1'b0;
    for (int i = 0; i < NRET; i++) begin
      if (lptr == LW'(i)) begin
        lane_valid = head.valid[i];
        lane_pc    = head.pc[i];
        lane_itype = head.itype[i];
        lane_compr = head.compr[i];
      end
    end
  end

  assign is_trap    = (lane_itype == ITYPE_EXC) || (lane_itype == ITYPE_INT);
  assign is_special = (lane_itype > ITYPE_INT);
  assign inc        = lane_compr ? (IRETIRE_LEN + 1)'(1) : (IRETIRE_LEN + 1)'(2);
  assign sum        = {1'b0, acc} + inc;
  assign overflow   = open && (sum > ACC_MAX);

`ifdef MURE_PACKER_PRIV_CHANGE_EN
  assign priv_change = open && (head.priv != open_priv);
  assign close_priv  = open ? open_priv : head.priv;
`else
  assign priv_change = 1'b0;
  assign close_priv  = head.priv;
`endif

  // Decide what the current lane does to the open block and whether a block closes
  always_comb begin
    close       = 1'b0;
    consume     = 1'b1;
    trap        = 1'b0;
    c_iretire   = '0;
    c_ilastsize = 1'b0;
    c_itype     = ITYPE_STD;
    c_cause     = '0;
    c_tval      = '0;
    c_iaddr     = '0;
    n_acc       = acc;
    n_open      = open;
    n_start     = iaddr_start;
    n_last      = last_compr;
`ifdef MURE_PACKER_PRIV_CHANGE_EN
    n_open_priv = open_priv;
`endif
    if (lane_valid) begin
      if (priv_change || overflow) begin
        close       = 1'b1;
        consume     = 1'b0;
        c_iretire   = acc;
        c_ilastsize = !last_compr;
        c_iaddr     = iaddr_start;
        n_acc       = '0;
        n_open      = 1'b0;
      end else if (is_trap) begin
        close       = 1'b1;
        trap        = 1'b1;
        c_iretire   = acc;
        c_ilastsize = open ? !last_compr : 1'b0;
        c_itype     = lane_itype;
        c_cause     = head.cause;
        c_tval      = head.tval;
        c_iaddr     = open ? iaddr_start : lane_pc;
        n_acc       = '0;
        n_open      = 1'b0;
      end else begin
        n_acc   = open ? sum[IRETIRE_LEN-1:0] : inc[IRETIRE_LEN-1:0];
        n_start = open ? iaddr_start : lane_pc;
        n_open  = 1'b1;
        n_last  = lane_compr;
`ifdef MURE_PACKER_PRIV_CHANGE_EN
        if (!open) begin
          n_open_priv = head.priv;
        end
`endif
        if (is_special) begin
          close       = 1'b1;
          c_iretire   = n_acc;
          c_ilastsize = !lane_compr;
          c_itype     = lane_itype;
          c_iaddr     = n_start;
          n_acc       = '0;
          n_open      = 1'b0;
        end
      end
    end
    group_done = consume && (trap || (lptr == LW'(NRET - 1)));
    fill_next  = close ? fill + FW'(1) : fill;
    beat_full  = (fill_next == FW'(NBLK));
    for (int i = 0; i < NBLK; i++) begin
      therm[i] = (FW'(i) < fill_next);
    end
  end

  // Packing FSM: walk lanes, fill slots, hold a beat until the encoder takes it
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state         <= IDLE;
      rd_ptr        <= '0;
      lptr          <= '0;
      acc           <= '0;
      open          <= 1'b0;
      iaddr_start   <= '0;
      last_compr    <= 1'b0;
      fill          <= '0;
      out_valid     <= '0;
      blk_iretire   <= '0;
      blk_ilastsize <= '0;
      blk_itype     <= '0;
      blk_cause     <= '0;
      blk_tval      <= '0;
      blk_priv      <= '0;
      blk_iaddr     <= '0;
`ifdef MURE_PACKER_PRIV_CHANGE_EN
      open_priv     <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (!empty) begin
            state <= SCAN;
          end
        end
        SCAN: begin
          if (empty) begin
            state <= IDLE;
          end else begin
            acc         <= n_acc;
            open        <= n_open;
            iaddr_start <= n_start;
            last_compr  <= n_last;
`ifdef MURE_PACKER_PRIV_CHANGE_EN
            open_priv   <= n_open_priv;
`endif
            for (int i = 0; i < NBLK; i++) begin
              if (close && (fill == FW'(i))) begin
                blk_iretire[i]   <= c_iretire;
                blk_ilastsize[i] <= c_ilastsize;
                blk_itype[i]     <= c_itype;
                blk_cause[i]     <= c_cause;
                blk_tval[i]      <= c_tval;
                blk_priv[i]      <= close_priv;
                blk_iaddr[i]     <= c_iaddr;
              end
            end
            fill <= fill_next;
            if (consume) begin
              lptr <= group_done ? '0 : lptr + LW'(1);
            end
            if (group_done) begin
              rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (beat_full || (group_done && (fill_next != '0))) begin
              state     <= DRAIN;
              out_valid <= therm;
            end
          end
        end
        DRAIN: begin
          if (bus.out_ready_i) begin
            fill      <= '0;
            out_valid <= '0;
            state     <= empty ? IDLE : SCAN;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
